// File: rtl/run_len_pkg.sv
// run_len_pkg
//   Shared definitions for the run-length detector.
//   - state_t and the IDLE/RUN/HIT/LONG encoding that appears on the state port
//   - params_legal(): returns 1 when the thresholds and counter width are
//     consistent. The top level calls it at elaboration time.
package run_len_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;  // no run in progress
    localparam state_t ST_RUN  = 2'd1;  // 0 < run_len < HIT_LEN
    localparam state_t ST_HIT  = 2'd2;  // HIT_LEN <= run_len < END_LEN
    localparam state_t ST_LONG = 2'd3;  // run_len >= END_LEN

    // The upper limit on cnt_w keeps the 1 << cnt_w term inside a 32-bit int.
    function automatic bit params_legal(
        input int cnt_w,
        input int hit_len,
        input int end_len
    );
        int sat_val;
        if (cnt_w < 1 || cnt_w > 30) begin
            return 1'b0;
        end
        sat_val = (1 << cnt_w) - 1;
        return (hit_len >= 1) && (hit_len < end_len) && (end_len <= sat_val);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones and has a synchronous clear.
//   clear takes priority over increment.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset (q -> 0)
//     clr  synchronous clear (q -> 0); wins over inc
//     inc  increment request; ignored once q is all-ones
//     q    current count
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q_reg <= '0;
        end else if (inc && (q_reg != {W{1'b1}})) begin
            q_reg <= q_reg + 1'b1;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/run_length_detector.sv
// run_length_detector
//   Tracks the length of the current run of matching bits in a serial stream.
//   Optional sample qualifier. Selectable run polarity. Counts terminated long
//   runs, saturating.
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous active-high reset; overrides en and clr_evt
//     en        sample qualifier; in/polarity are consumed only when en=1
//     in        serial data bit
//     polarity  0: runs of 1s count, 1: runs of 0s count
//     clr_evt   synchronous clear of evt_cnt (wins over a same-cycle event)
//     z1        level: current run length >= HIT_LEN
//     z2        one-cycle pulse: a run of length >= END_LEN just ended
//     run_len   current run length, saturating at 2^CNT_W-1
//     state     IDLE/RUN/HIT/LONG, decoded from run_len
//     evt_cnt   number of z2 pulses since reset/clear, saturating
//   All outputs come from registers.
module run_length_detector
    import run_len_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int HIT_LEN = 3,
    parameter int END_LEN = 4,
    parameter int EVT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             polarity,
    input  logic             clr_evt,
    output logic             z1,
    output logic             z2,
    output logic [CNT_W-1:0] run_len,
    output logic [1:0]       state,
    output logic [EVT_W-1:0] evt_cnt
);

    generate
        if (!params_legal(CNT_W, HIT_LEN, END_LEN)) begin : g_param_check
            $error("run_length_detector: need 1 <= HIT_LEN < END_LEN <= 2^CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] SAT_V = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] HIT_V = CNT_W'(HIT_LEN);
    localparam logic [CNT_W-1:0] END_V = CNT_W'(END_LEN);

    logic             match;
    logic             acc_match;
    logic             acc_break;
    logic [CNT_W-1:0] run_len_next;
    logic             z2_next;
    logic             z1_next;
    state_t           state_next;

    state_t           state_reg;
    logic             z1_reg;
    logic             z2_reg;

    always_comb begin
        match     = in ^ polarity;
        acc_match = en & match;
        acc_break = en & ~match;

        // This is the value the run-length counter will hold after this edge.
        // state and z1 are decoded from it so that all three registers
        // change together.
        run_len_next = run_len;
        if (acc_break) begin
            run_len_next = '0;
        end else if (acc_match && (run_len != SAT_V)) begin
            run_len_next = run_len + 1'b1;
        end

        // Whether the run qualifies depends on its length before the reset.
        z2_next = acc_break && (run_len >= END_V);

        if (run_len_next == '0) begin
            state_next = ST_IDLE;
        end else if (run_len_next < HIT_V) begin
            state_next = ST_RUN;
        end else if (run_len_next < END_V) begin
            state_next = ST_HIT;
        end else begin
            state_next = ST_LONG;
        end

        z1_next = (run_len_next >= HIT_V);
    end

    sat_counter #(
        .W (CNT_W)
    ) u_run_cnt (
        .clk (clk),
        .rst (rst),
        .clr (acc_break),
        .inc (acc_match),
        .q   (run_len)
    );

    // Driving the increment from z2_next updates evt_cnt on the same edge as z2.
    sat_counter #(
        .W (EVT_W)
    ) u_evt_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_evt),
        .inc (z2_next),
        .q   (evt_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            z1_reg    <= 1'b0;
            z2_reg    <= 1'b0;
        end else begin
            // z2_next is already 0 on a non-accepted edge. state and z1 hold
            // on such an edge because run_len_next equals run_len.
            state_reg <= state_next;
            z1_reg    <= z1_next;
            z2_reg    <= z2_next;
        end
    end

    assign state = state_reg;
    assign z1    = z1_reg;
    assign z2    = z2_reg;

endmodule

// File: tb/tb_run_length_detector.sv
// tb_run_length_detector
//   Scoreboard bench. The driver applies one input vector per cycle and pushes
//   the expected outputs from a behavioural model into a queue. The monitor
//   pops one entry after every clock edge and compares it with the outputs of
//   two DUTs: the default build, and an EVT_W=2 build for event saturation.
module tb_run_length_detector;

    localparam int CNT_W   = 4;
    localparam int HIT_LEN = 3;
    localparam int END_LEN = 4;
    localparam int RUN_MAX = (1 << CNT_W) - 1;
    localparam int EVT_MAX = 255;
    localparam int EV2_MAX = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       in = 1'b0;
    logic       polarity = 1'b0;
    logic       clr_evt = 1'b0;

    logic       z1, z2, z1_b, z2_b;
    logic [3:0] run_len, run_len_b;
    logic [1:0] state, state_b;
    logic [7:0] evt_cnt;
    logic [1:0] evt_cnt_b;

    always #5 clk = ~clk;

    run_length_detector #(.CNT_W(CNT_W), .HIT_LEN(HIT_LEN), .END_LEN(END_LEN), .EVT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .in(in), .polarity(polarity), .clr_evt(clr_evt),
        .z1(z1), .z2(z2), .run_len(run_len), .state(state), .evt_cnt(evt_cnt)
    );

    run_length_detector #(.CNT_W(CNT_W), .HIT_LEN(HIT_LEN), .END_LEN(END_LEN), .EVT_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .in(in), .polarity(polarity), .clr_evt(clr_evt),
        .z1(z1_b), .z2(z2_b), .run_len(run_len_b), .state(state_b), .evt_cnt(evt_cnt_b)
    );

    typedef struct {
        int rl;
        int st;
        int z1;
        int z2;
        int ev;
        int ev2;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   txn = 0;

    // Model state: true run length (not saturated) and the number of events
    // since the last clear, for each counter width.
    int m_run = 0;
    int m_ev = 0;
    int m_ev2 = 0;
    int m_z2 = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic step(input logic r, input logic e, input logic d,
                        input logic p, input logic c);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; in = d; polarity = p; clr_evt = c;
        if (r) begin
            m_run = 0; m_z2 = 0; m_ev = 0; m_ev2 = 0;
        end else begin
            m_z2 = 0;
            if (e) begin
                if ((d ^ p) == 1'b1) begin
                    m_run = m_run + 1;
                end else begin
                    m_z2 = (m_run >= END_LEN) ? 1 : 0;
                    m_run = 0;
                end
            end
            if (c) begin
                m_ev = 0; m_ev2 = 0;
            end else if (m_z2 == 1) begin
                m_ev = imin(m_ev + 1, EVT_MAX);
                m_ev2 = imin(m_ev2 + 1, EV2_MAX);
            end
        end
        x.rl = imin(m_run, RUN_MAX);
        x.st = (x.rl == 0) ? 0 : (x.rl < HIT_LEN) ? 1 : (x.rl < END_LEN) ? 2 : 3;
        x.z1 = (x.rl >= HIT_LEN) ? 1 : 0;
        x.z2 = m_z2;
        x.ev = m_ev;
        x.ev2 = m_ev2;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL txn=%0d %s: got %0d expected %0d", txn, name, act, req);
        end
    endtask

    // Monitor: the outputs settle after each edge, so compare 1 time unit later.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                txn++;
                chk("run_len", int'(run_len), x.rl);
                chk("state", int'(state), x.st);
                chk("z1", int'(z1), x.z1);
                chk("z2", int'(z2), x.z2);
                chk("evt_cnt", int'(evt_cnt), x.ev);
                chk("evt_cnt_w2", int'(evt_cnt_b), x.ev2);
                chk("run_len_w2", int'(run_len_b), x.rl);
                $display("txn %0d rst=%0b en=%0b in=%0b pol=%0b clr=%0b -> run_len=%0d state=%0d z1=%0b z2=%0b evt=%0d evt2=%0d",
                         txn, rst, en, in, polarity, clr_evt, run_len, state, z1, z2, evt_cnt, evt_cnt_b);
            end
        end
    end

    initial begin
        logic pol_r;
        logic mbit;
        // Reset state.
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1);
        // Threshold reached without termination: 1,1,1,0.
        repeat (3) step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        // Long run: 1 x5 then 0.
        repeat (5) step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        // Enable gap: in=1, en=0 for 3 cycles with in=0, then 1,1.
        step(0, 1, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (2) step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        // Saturation: 1 x20 then 0.
        repeat (20) step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        // Five long runs: the EVT_W=2 counter sticks at 3.
        repeat (5) begin
            repeat (4) step(0, 1, 1, 0, 0);
            step(0, 1, 0, 0, 0);
        end
        // Polarity 1: zeros x4 then 1.
        repeat (4) step(0, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0);
        // Toggle polarity mid-run: in stays 1 while the match inverts.
        repeat (2) step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0);
        step(0, 1, 0, 1, 0);
        // Clear coincident with a z2 pulse.
        repeat (4) step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 1);
        // Reset during a LONG run.
        repeat (6) step(0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        // Randomised traffic, biased towards long runs.
        pol_r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) pol_r = ~pol_r;
            mbit = ($urandom_range(0, 9) < 8);
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 3) != 0),
                 mbit ^ pol_r,
                 pol_r,
                 ($urandom_range(0, 29) == 0));
        end
        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
